axis_receiver: RTL and testbench
================================

AXIS_RECEIVER -- requirements
Module: axis_receiver

Interface
REQ-001 Parameter DATA_WIDTH, default 16: TDATA/out_data width in bits, a multiple of 8.
REQ-002 Parameter ID_WIDTH, default 8: TID/out_id width.
REQ-003 Parameter DEPTH, default 4: FIFO entries, a power of two, at least 2.
REQ-004 ACLK  in  1  clock; all logic on the rising edge.
REQ-005 ARESET  in  1  asynchronous, active-high reset.
REQ-006 TVALID  in  1  upstream beat valid.
REQ-007 TREADY  out  1  receiver can accept a beat.
REQ-008 TDATA  in  DATA_WIDTH  beat data.
REQ-009 TKEEP  in  DATA_WIDTH/8  byte-valid mask.
REQ-010 TLAST  in  1  final beat of the packet.
REQ-011 TUSER  in  2  sideband.
REQ-012 TID  in  ID_WIDTH  stream identifier.
REQ-013 out_valid  out  1  FIFO head valid.
REQ-014 out_ready  in  1  consumer takes the head.
REQ-015 out_data/out_keep/out_last/out_user/out_id  out  DATA_WIDTH, DATA_WIDTH/8, 1, 2, ID_WIDTH  FIFO head fields.
REQ-016 beat_cnt  out  16  beats accepted in the current packet.
REQ-017 pkt_done  out  1  one-cycle pulse when a TLAST beat is accepted.
REQ-018 id_err  out  1  one-cycle pulse when TID changes mid-packet.
REQ-019 rx_state  out  2  FSM state: 0=IDLE, 1=IN_PKT.

Function
REQ-020 A beat SHALL be accepted on any rising edge where TVALID and TREADY are both 1.
REQ-021 An accepted beat SHALL write {TDATA, TKEEP, TLAST, TUSER, TID} into the FIFO tail.
REQ-022 TREADY SHALL be registered: 1 when FIFO occupancy after the current edge is less than DEPTH, otherwise 0.
REQ-023 A same-edge pop SHALL be counted toward that occupancy, so the FIFO sustains one beat per cycle when full and out_ready=1.
REQ-024 out_valid SHALL equal (occupancy != 0); out_* SHALL show the head entry combinationally from storage.
REQ-025 A pop SHALL occur on an edge with out_valid and out_ready both 1.
REQ-026 A simultaneous push and pop SHALL leave occupancy unchanged.
REQ-027 A push to an empty FIFO SHALL make out_valid 1 on the next cycle (latency 1).
REQ-028 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; occupancy SHALL be log2(DEPTH)+1 bits.
REQ-029 IDLE: accepting a non-TLAST beat SHALL latch TID as pkt_id, set beat_cnt=1 and go to IN_PKT.
REQ-030 IDLE: accepting a TLAST beat (single-beat packet) SHALL set beat_cnt=1, pulse pkt_done and stay in IDLE.
REQ-031 IN_PKT: each accepted beat SHALL increment beat_cnt, which saturates at 16'hFFFF.
REQ-032 IN_PKT: accepting a TLAST beat SHALL pulse pkt_done and return to IDLE.
REQ-033 beat_cnt SHALL hold its final packet value until the next packet's first beat is accepted.
REQ-034 IN_PKT: an accepted beat with TID != pkt_id SHALL pulse id_err; the beat SHALL still be stored and counted, and pkt_id is not updated.
REQ-035 Cycles where TVALID=0 while in IN_PKT SHALL not change state or counters.
REQ-036 TKEEP and TUSER SHALL be carried through unmodified and not interpreted.
REQ-037 Unused rx_state encodings SHALL return to IDLE on the next edge.

Reset
REQ-038 While ARESET=1, outputs SHALL be: TREADY=0, out_valid=0, pkt_done=0, id_err=0, beat_cnt=0, rx_state=IDLE.
REQ-039 While ARESET=1, pointers and occupancy SHALL be 0.
REQ-040 Reset asserted mid-packet SHALL discard all FIFO contents and the partial packet.
REQ-041 TREADY SHALL rise on the first rising edge after ARESET deasserts.
REQ-042 FIFO storage contents are not reset.

Verification
REQ-043 Reset, then 3 beats 0x0011, 0x0022, 0x0033 (TLAST on the third, TID=5) with out_ready=1 -> out_data in order; pkt_done pulses once; beat_cnt=3; rx_state back to 0.
REQ-044 out_ready=0 with TVALID held at 1 -> exactly DEPTH=4 beats accepted, then TREADY=0; raising out_ready -> TREADY=1 one cycle later and no beat lost or duplicated.
REQ-045 Continuous TVALID=1 and out_ready=1 for 20 beats -> throughput 1 beat/cycle; pointer wrap is exercised; data order is preserved.
REQ-046 Single-beat packet (TLAST on the first beat) -> pkt_done pulse, beat_cnt=1, rx_state stays 0.
REQ-047 TID=3 on the first beat, then TID=4 on the second, within one packet -> one id_err pulse; both beats are output.
REQ-048 ARESET pulsed after 2 beats of a 4-beat packet -> out_valid=0, beat_cnt=0, TREADY=0 during reset; the next packet is received cleanly.

Source files
------------

// File: rtl/axis_receiver_if.sv
// AXI4-Stream sink plus FIFO read port and packet status for axis_receiver.
// The receiver uses the slave modport; the stream source and consumer use master.
interface axis_receiver_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 8
) ();
  logic                    TVALID;
  logic                    TREADY;
  logic [DATA_WIDTH-1:0]   TDATA;
  logic [DATA_WIDTH/8-1:0] TKEEP;
  logic                    TLAST;
  logic [1:0]              TUSER;
  logic [ID_WIDTH-1:0]     TID;

  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   out_data;
  logic [DATA_WIDTH/8-1:0] out_keep;
  logic                    out_last;
  logic [1:0]              out_user;
  logic [ID_WIDTH-1:0]     out_id;

  logic [15:0]             beat_cnt;
  logic                    pkt_done;
  logic                    id_err;
  logic [1:0]              rx_state;

  modport slave (
    input  TVALID, TDATA, TKEEP, TLAST, TUSER, TID, out_ready,
    output TREADY, out_valid, out_data, out_keep, out_last, out_user, out_id,
    output beat_cnt, pkt_done, id_err, rx_state
  );

  modport master (
    output TVALID, TDATA, TKEEP, TLAST, TUSER, TID, out_ready,
    input  TREADY, out_valid, out_data, out_keep, out_last, out_user, out_id,
    input  beat_cnt, pkt_done, id_err, rx_state
  );
endinterface

// File: rtl/axis_receiver.sv
// AXI4-Stream receiver: buffers beats in a small FIFO and tracks packet
// framing (beat count, completion pulse, mid-packet TID change pulse).
module axis_receiver #(
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int DEPTH      = 4
) (
  input  logic           ACLK,
  input  logic           ARESET,
  axis_receiver_if.slave axis
);
  localparam int KEEP_W   = DATA_WIDTH / 8;
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int USER_LSB = ID_WIDTH;
  localparam int LAST_BIT = ID_WIDTH + 2;
  localparam int KEEP_LSB = ID_WIDTH + 3;
  localparam int DATA_LSB = KEEP_LSB + KEEP_W;
  localparam int ENTRY_W  = DATA_LSB + DATA_WIDTH;

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IN_PKT = 2'd1
  } rx_state_t;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic [PTR_W:0]     w_count_next;
  logic               r_tready;
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_head;

  assign w_push = axis.TVALID & r_tready;
  assign w_pop  = (r_count != '0) & axis.out_ready;

  // NOTE: every variable written in always_comb takes a default first, so no path can infer a latch.
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)      w_count_next = r_count + CNT_ONE;
    else if (!w_push && w_pop) w_count_next = r_count - CNT_ONE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_tready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count  <= w_count_next;
      // Looking at next occupancy lets a full FIFO keep streaming when the head drains.
      r_tready <= (w_count_next < FULL_CNT);
    end
  end

  // NOTE: storage has no reset; stale entries are never visible because out_valid gates the head.
  always_ff @(posedge ACLK) begin
    if (w_push) r_mem[r_wr_ptr] <= {axis.TDATA, axis.TKEEP, axis.TLAST, axis.TUSER, axis.TID};
  end

  assign w_head         = r_mem[r_rd_ptr];
  assign axis.TREADY    = r_tready;
  assign axis.out_valid = (r_count != '0);
  assign axis.out_data  = w_head[DATA_LSB +: DATA_WIDTH];
  assign axis.out_keep  = w_head[KEEP_LSB +: KEEP_W];
  assign axis.out_last  = w_head[LAST_BIT];
  assign axis.out_user  = w_head[USER_LSB +: 2];
  assign axis.out_id    = w_head[ID_WIDTH-1:0];

  rx_state_t           r_state;
  rx_state_t           w_state_next;
  logic [15:0]         r_beat_cnt;
  logic [15:0]         w_beat_cnt_next;
  logic [ID_WIDTH-1:0] r_pkt_id;
  logic [ID_WIDTH-1:0] w_pkt_id_next;
  logic                r_pkt_done;
  logic                w_pkt_done_next;
  logic                r_id_err;
  logic                w_id_err_next;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
      r_pkt_id   <= '0;
      r_pkt_done <= 1'b0;
      r_id_err   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_beat_cnt <= w_beat_cnt_next;
      r_pkt_id   <= w_pkt_id_next;
      r_pkt_done <= w_pkt_done_next;
      r_id_err   <= w_id_err_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_beat_cnt_next = r_beat_cnt;
    w_pkt_id_next   = r_pkt_id;
    w_pkt_done_next = 1'b0;
    w_id_err_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_push) begin
          w_beat_cnt_next = 16'd1;
          if (axis.TLAST) begin
            w_pkt_done_next = 1'b1;
          end else begin
            w_pkt_id_next = axis.TID;
            w_state_next  = ST_IN_PKT;
          end
        end
      end
      ST_IN_PKT: begin
        if (w_push) begin
          if (r_beat_cnt != 16'hFFFF) w_beat_cnt_next = r_beat_cnt + 16'd1;
          // A mismatching beat is flagged but still stored; the packet keeps its first TID.
          if (axis.TID != r_pkt_id) w_id_err_next = 1'b1;
          if (axis.TLAST) begin
            w_pkt_done_next = 1'b1;
            w_state_next    = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign axis.beat_cnt = r_beat_cnt;
  assign axis.pkt_done = r_pkt_done;
  assign axis.id_err   = r_id_err;
  assign axis.rx_state = r_state;
endmodule

// File: tb/tb_axis_receiver.sv
// Directed self-checking bench for axis_receiver: framing, back-pressure,
// streaming throughput, TID mismatch and mid-packet reset.
module tb_axis_receiver;
  logic ACLK   = 1'b0;
  logic ARESET = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   n_acc    = 0;
  int   acc0;
  int   k;
  logic [15:0] rx_q  [$];
  logic [15:0] exp_q [$];

  axis_receiver_if #(.DATA_WIDTH(16), .ID_WIDTH(8)) axis ();

  axis_receiver #(.DATA_WIDTH(16), .ID_WIDTH(8), .DEPTH(4)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .axis   (axis)
  );

  always #5 ACLK = ~ACLK;

  // Inputs are stable by the falling edge, so handshakes seen here complete on the next rising edge.
  always @(negedge ACLK) begin
    if (!ARESET && axis.TVALID && axis.TREADY) n_acc++;
    if (!ARESET && axis.out_valid && axis.out_ready) rx_q.push_back(axis.out_data);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive(input logic [15:0] data, input logic [1:0] keep, input logic last,
                       input logic [1:0] user, input logic [7:0] id);
    axis.TVALID = 1'b1;
    axis.TDATA  = data;
    axis.TKEEP  = keep;
    axis.TLAST  = last;
    axis.TUSER  = user;
    axis.TID    = id;
  endtask

  task automatic idle();
    axis.TVALID = 1'b0;
    axis.TLAST  = 1'b0;
  endtask

  task automatic drain();
    axis.out_ready = 1'b1;
    for (int c = 0; c < 16 && axis.out_valid; c++) tick();
    check("drain_empty", axis.out_valid, 1'b0);
  endtask

  task automatic compare_rx(input string tag);
    check($sformatf("%s_count", tag), rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_data[%0d]", tag, i), rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    axis.out_ready = 1'b0;
    idle();
    axis.TDATA = '0; axis.TKEEP = '0; axis.TUSER = '0; axis.TID = '0;

    // Reset state
    tick(); tick();
    check("rst_tready",    axis.TREADY,    1'b0);
    check("rst_out_valid", axis.out_valid, 1'b0);
    check("rst_pkt_done",  axis.pkt_done,  1'b0);
    check("rst_id_err",    axis.id_err,    1'b0);
    check("rst_beat_cnt",  axis.beat_cnt,  16'd0);
    check("rst_rx_state",  axis.rx_state,  2'd0);
    ARESET = 1'b0;
    check("tready_before_edge", axis.TREADY, 1'b0);
    tick();
    check("tready_after_rst", axis.TREADY, 1'b1);

    // Three-beat packet, TID 5, consumer always ready
    axis.out_ready = 1'b1;
    drive(16'h0011, 2'b11, 1'b0, 2'b00, 8'd5); tick();
    check("p1_b0_valid",    axis.out_valid, 1'b1);
    check("p1_b0_cnt",      axis.beat_cnt,  16'd1);
    check("p1_b0_state",    axis.rx_state,  2'd1);
    check("p1_b0_done",     axis.pkt_done,  1'b0);
    drive(16'h0022, 2'b11, 1'b0, 2'b00, 8'd5); tick();
    check("p1_b1_cnt",      axis.beat_cnt,  16'd2);
    check("p1_b1_done",     axis.pkt_done,  1'b0);
    drive(16'h0033, 2'b11, 1'b1, 2'b00, 8'd5); tick();
    check("p1_b2_cnt",      axis.beat_cnt,  16'd3);
    check("p1_b2_done",     axis.pkt_done,  1'b1);
    check("p1_b2_state",    axis.rx_state,  2'd0);
    idle(); tick();
    check("p1_done_cleared", axis.pkt_done, 1'b0);
    check("p1_cnt_held",     axis.beat_cnt, 16'd3);
    drain();
    exp_q = '{16'h0011, 16'h0022, 16'h0033};
    compare_rx("p1");

    // Back-pressure: consumer stalled, source keeps TVALID high
    axis.out_ready = 1'b0;
    acc0 = n_acc;
    for (int c = 0; c < 6; c++) begin
      k = n_acc - acc0;
      drive(16'h0100 + 16'(k), 2'b01, 1'b0, 2'b10, 8'd1);
      tick();
    end
    check("full_accepted",  n_acc - acc0,   4);
    check("full_tready",    axis.TREADY,    1'b0);
    check("full_head",      axis.out_data,  16'h0100);
    check("full_cnt",       axis.beat_cnt,  16'd4);
    axis.out_ready = 1'b1;
    tick();
    check("unstall_tready", axis.TREADY,    1'b1);
    check("unstall_head",   axis.out_data,  16'h0101);
    for (int c = 0; c < 10; c++) begin
      k = n_acc - acc0;
      if (k >= 6) break;
      drive(16'h0100 + 16'(k), 2'b01, k == 5, 2'b10, 8'd1);
      tick();
    end
    idle();
    check("bp_total_accepted", n_acc - acc0,  6);
    check("bp_cnt",            axis.beat_cnt, 16'd6);
    drain();
    for (int i = 0; i < 6; i++) exp_q.push_back(16'h0100 + 16'(i));
    compare_rx("bp");

    // Continuous 20-beat stream: one beat per cycle, pointers wrap several times
    acc0 = n_acc;
    for (int i = 0; i < 20; i++) begin
      drive(16'h1000 + 16'(i), 2'b11, i == 19, 2'b01, 8'd2);
      tick();
    end
    check("stream_accepted", n_acc - acc0,   20);
    check("stream_cnt",      axis.beat_cnt,  16'd20);
    check("stream_done",     axis.pkt_done,  1'b1);
    check("stream_state",    axis.rx_state,  2'd0);
    idle();
    drain();
    for (int i = 0; i < 20; i++) exp_q.push_back(16'h1000 + 16'(i));
    compare_rx("stream");

    // Single-beat packet; sideband fields pass through untouched
    axis.out_ready = 1'b0;
    drive(16'hABCD, 2'b10, 1'b1, 2'b11, 8'd7); tick();
    check("single_done",  axis.pkt_done,  1'b1);
    check("single_cnt",   axis.beat_cnt,  16'd1);
    check("single_state", axis.rx_state,  2'd0);
    check("single_data",  axis.out_data,  16'hABCD);
    check("single_keep",  axis.out_keep,  2'b10);
    check("single_last",  axis.out_last,  1'b1);
    check("single_user",  axis.out_user,  2'b11);
    check("single_id",    axis.out_id,    8'd7);
    idle(); tick();
    check("single_done_clr", axis.pkt_done, 1'b0);
    drain();
    exp_q = '{16'hABCD};
    compare_rx("single");

    // TID changes on the second beat of a packet
    drive(16'h0301, 2'b11, 1'b0, 2'b00, 8'd3); tick();
    check("tid_b0_err",   axis.id_err,   1'b0);
    check("tid_b0_state", axis.rx_state, 2'd1);
    drive(16'h0402, 2'b11, 1'b1, 2'b00, 8'd4); tick();
    check("tid_b1_err",   axis.id_err,   1'b1);
    check("tid_b1_done",  axis.pkt_done, 1'b1);
    check("tid_b1_cnt",   axis.beat_cnt, 16'd2);
    idle(); tick();
    check("tid_err_clr",  axis.id_err,   1'b0);
    drain();
    exp_q = '{16'h0301, 16'h0402};
    compare_rx("tid");

    // Reset in the middle of a 4-beat packet
    axis.out_ready = 1'b0;
    drive(16'h0901, 2'b11, 1'b0, 2'b00, 8'd9); tick();
    drive(16'h0902, 2'b11, 1'b0, 2'b00, 8'd9); tick();
    check("pre_rst_cnt",   axis.beat_cnt, 16'd2);
    check("pre_rst_state", axis.rx_state, 2'd1);
    idle();
    ARESET = 1'b1;
    #1;
    check("mid_rst_valid",  axis.out_valid, 1'b0);
    check("mid_rst_cnt",    axis.beat_cnt,  16'd0);
    check("mid_rst_tready", axis.TREADY,    1'b0);
    check("mid_rst_state",  axis.rx_state,  2'd0);
    tick();
    check("mid_rst_tready_edge", axis.TREADY, 1'b0);
    ARESET = 1'b0;
    tick();
    check("post_rst_tready", axis.TREADY,    1'b1);
    check("post_rst_valid",  axis.out_valid, 1'b0);
    axis.out_ready = 1'b1;
    rx_q.delete();
    drive(16'h0A01, 2'b11, 1'b0, 2'b00, 8'd10); tick();
    check("post_rst_b0_cnt", axis.beat_cnt, 16'd1);
    drive(16'h0A02, 2'b11, 1'b1, 2'b00, 8'd10); tick();
    check("post_rst_b1_cnt",  axis.beat_cnt, 16'd2);
    check("post_rst_b1_done", axis.pkt_done, 1'b1);
    check("post_rst_b1_err",  axis.id_err,   1'b0);
    idle();
    drain();
    exp_q = '{16'h0A01, 16'h0A02};
    compare_rx("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
